// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, funct3 op codes, FSM states and op decode
// for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  function automatic logic is_div(logic [2:0] op);
    return op >= OP_DIV;
  endfunction

  function automatic logic is_signed_a(logic [2:0] op);
    return op != OP_MULHU && op != OP_DIVU && op != OP_REMU;
  endfunction

  function automatic logic is_signed_b(logic [2:0] op);
    return op == OP_MUL || op == OP_MULH
        || op == OP_DIV || op == OP_REM;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned 64-step shift-add multiply / restoring divide.
// in: init, step, div_mode, a_in, b_in; out: acc ({hi,lo}), fin.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   a_in,
  input  logic [XLEN-1:0]   b_in,
  output logic [2*XLEN-1:0] acc,
  output logic              fin
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   m_q;
  logic              div_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [XLEN:0]     add;
  logic [XLEN:0]     shf;
  logic [XLEN-1:0]   dif;
  logic [XLEN-1:0]   rem_n;
  logic              ge;

  // mul: acc = {partial hi, remaining multiplier bits}
  // div: acc = {partial remainder, dividend/quotient bits}
  always_comb begin
    add = {1'b0, acc_q[2*XLEN-1:XLEN]}
        + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_nxt = {add, acc_q[XLEN-1:1]};
    shf = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge = shf >= {1'b0, m_q};
    dif = shf[XLEN-1:0] - m_q;
    rem_n = ge ? dif : shf[XLEN-1:0];
    div_nxt = {rem_n, acc_q[XLEN-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (init) begin
      div_q <= div_mode;
      m_q   <= div_mode ? b_in : a_in;
      acc_q <= {{XLEN{1'b0}}, div_mode ? a_in : b_in};
      cnt_q <= '0;
    end else if (step && !fin) begin
      acc_q <= div_q ? div_nxt : mul_nxt;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc = acc_q;
  assign fin = cnt_q == CNT_W'(XLEN);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV64M mul/div unit, FSM + sign handling + fast path.
// in: start, op, operand_a/b, rd_in, flush; out: busy, done, result, rd_out, wb_en.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);

  state_t state_q, state_d;

  logic            accept, step, load;
  logic [2:0]      op_q;
  logic            neg_a_q, neg_b_q, fast_q;
  logic [XLEN-1:0] fast_res_q, result_q;
  logic [4:0]      rd_q;

  logic            neg_a, neg_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, ovf, fast;
  logic [XLEN-1:0] fast_val;

  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   quot, remv, final_val;
  logic              fin;

  always_comb begin
    neg_a = is_signed_a(op) & operand_a[XLEN-1];
    neg_b = is_signed_b(op) & operand_b[XLEN-1];
    a_mag = neg_a ? -operand_a : operand_a;
    b_mag = neg_b ? -operand_b : operand_b;
    div_zero = operand_b == '0;
    ovf = (op == OP_DIV || op == OP_REM)
        && operand_a == {1'b1, {(XLEN-1){1'b0}}}
        && operand_b == '1;
    fast = is_div(op) & (div_zero | ovf);
    // op[1] separates REM/REMU from DIV/DIVU
    fast_val = '0;
    unique case (1'b1)
      div_zero && !op[1]:  fast_val = '1;
      div_zero && op[1]:   fast_val = operand_a;
      !div_zero && !op[1]: fast_val = {1'b1, {(XLEN-1){1'b0}}};
      default:             fast_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // fast path spends its one cycle in CALC so done lands on E1
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (fast_q || fin) begin
          load    = 1'b1;
          state_d = S_DONE;
        end else begin
          step = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  muldiv_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (accept),
    .step     (step),
    .div_mode (is_div(op)),
    .a_in     (a_mag),
    .b_in     (b_mag),
    .acc      (acc),
    .fin      (fin)
  );

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc : acc;
    quot = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remv = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    final_val = '0;
    unique case (1'b1)
      op_q == OP_MUL:                   final_val = prod[XLEN-1:0];
      !is_div(op_q) && op_q != OP_MUL: final_val = prod[2*XLEN-1:XLEN];
      is_div(op_q) && !op_q[1]:         final_val = quot;
      is_div(op_q) && op_q[1]:          final_val = remv;
      default:                          final_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      rd_q       <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        op_q       <= op;
        neg_a_q    <= neg_a;
        neg_b_q    <= neg_b;
        fast_q     <= fast;
        fast_res_q <= fast_val;
        rd_q       <= rd_in;
      end
      if (load) result_q <= fast_q ? fast_res_q : final_val;
    end
  end

  assign busy   = state_q != S_IDLE;
  assign done   = state_q == S_DONE;
  assign result = result_q;
  assign rd_out = rd_q;
  assign wb_en  = done && rd_q != '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Drives and samples on the falling clock edge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [63:0] operand_a = '0;
  logic [63:0] operand_b = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        busy, done, wb_en;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .wb_en     (wb_en)
  );

  task automatic kick(input logic [2:0] o, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b; rd_in = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, wb_en, rd_out, result} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got b%0b d%0b w%0b rd%0d r%h want all 0",
               busy, done, wb_en, rd_out, result);
    end
  endtask

  task automatic test_mul;
    int lat;
    kick(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1);
    wait_done(lat);
    n_cmp++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_bad++;
      $display("FAIL mul_result: got %h want ffffffffffffffeb", result);
    end
    n_cmp++;
    if (lat !== 65) begin
      n_bad++;
      $display("FAIL mul_latency: got %0d want 65", lat);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_done_pulse: got done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_mulh;
    logic [2:0]  ops [3] = '{3'd3, 3'd1, 3'd2};
    logic [63:0] va  [3] = '{'1, '1, '1};
    logic [63:0] vb  [3] = '{'1, '1, 64'd2};
    logic [63:0] ex  [3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0, '1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      kick(ops[i], va[i], vb[i], 5'd2);
      wait_done(lat);
      n_cmp++;
      if (result !== ex[i] || lat !== 65) begin
        n_bad++;
        $display("FAIL mulh_%0d: got %h lat %0d want %h lat 65",
                 i, result, lat, ex[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [63:0] va  [4] = '{-64'sd20, -64'sd20, 64'd100, 64'd100};
    logic [63:0] vb  [4] = '{64'd6, 64'd6, 64'd7, 64'd7};
    logic [63:0] ex  [4] = '{64'hFFFF_FFFF_FFFF_FFFD,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'd14, 64'd2};
    int lat;
    for (int i = 0; i < 4; i++) begin
      kick(ops[i], va[i], vb[i], 5'd3);
      wait_done(lat);
      n_cmp++;
      if (result !== ex[i] || lat !== 65) begin
        n_bad++;
        $display("FAIL div_%0d: got %h lat %0d want %h lat 65",
                 i, result, lat, ex[i]);
      end
    end
  endtask

  task automatic test_fast;
    logic [2:0]  ops [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [63:0] va  [4] = '{64'd100, 64'h1234,
                             64'h8000_0000_0000_0000,
                             64'h8000_0000_0000_0000};
    logic [63:0] vb  [4] = '{64'd0, 64'd0, '1, '1};
    logic [63:0] ex  [4] = '{'1, 64'h1234,
                             64'h8000_0000_0000_0000, 64'd0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      kick(ops[i], va[i], vb[i], 5'd4);
      wait_done(lat);
      n_cmp++;
      if (result !== ex[i] || lat !== 1) begin
        n_bad++;
        $display("FAIL fast_%0d: got %h lat %0d want %h lat 1",
                 i, result, lat, ex[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    kick(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd6);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 3'd5; operand_a = 64'd100; operand_b = 64'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    n_cmp++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFEB || lat !== 54) begin
      n_bad++;
      $display("FAIL ignore_start: got %h lat %0d want ffffffffffffffeb lat 54",
               result, lat);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_no_queue: got busy %b want 0", busy);
    end
  endtask

  task automatic test_wb;
    int lat;
    kick(3'd0, 64'd3, 64'd4, 5'd0);
    wait_done(lat);
    n_cmp++;
    if (done !== 1'b1 || result !== 64'd12 || wb_en !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_rd0: got d%b r%0d w%b want d1 r12 w0",
               done, result, wb_en);
    end
    kick(3'd0, 64'd3, 64'd4, 5'd5);
    wait_done(lat);
    n_cmp++;
    if (wb_en !== 1'b1 || rd_out !== 5'd5 || result !== 64'd12) begin
      n_bad++;
      $display("FAIL wb_rd5: got w%b rd%0d r%0d want w1 rd5 r12",
               wb_en, rd_out, result);
    end
  endtask

  task automatic test_flush;
    bit seen = 1'b0;
    kick(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd7);
    repeat (29) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle: got busy %b done %b want 0 0", busy, done);
    end
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || result !== 64'd12) begin
      n_bad++;
      $display("FAIL flush_no_done: got seen %b r%0d want 0 r12", seen, result);
    end
  endtask

  task automatic test_reset_mid;
    kick(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, wb_en, rd_out, result} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got b%0b d%0b w%0b rd%0d r%h want all 0",
               busy, done, wb_en, rd_out, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_release: got busy %b r%h want 0 0", busy, result);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_fast;
    test_ignore_start;
    test_wb;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
